uart_tx_fifo_drain: RTL and testbench

//   UART transmitter that drains the byte FIFO (ADDRW/DATAW FIFO) through its read port.
//   - Sits directly downstream of the FIFO: pops one entry per frame and serialises it LSB-first.
//   - 8N1 framing by default; optional even parity.
//   - Drives the FIFO's i_rd_en; owns no storage beyond one shift register.

---
 rtl/uart_tx_fifo_drain.sv | 156 +++++++++++++++
 tb/tb_uart_tx_fifo_drain.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo_drain.sv
// uart_tx_fifo_drain
//   UART transmitter placed directly behind a byte FIFO. Whenever the FIFO
//   holds data and the line is free, the block pops the head entry and
//   sends it LSB-first as an 8N1 frame. With UART_TX_PARITY_EN defined, an
//   even-parity bit is added between the data bits and the stop bit.
//
// Parameters
//   DATAW    data bits per frame (matches the FIFO data width)
//   CLK_DIV  clk cycles per UART bit, >= 2
//
// Ports
//   clk             in   single clock, posedge
//   i_rst           in   synchronous active-high reset
//   i_fifo_empty    in   FIFO empty flag
//   i_fifo_rd_data  in   FIFO head entry, valid while not empty
//   o_fifo_rd_en    out  one-cycle pop strobe to the FIFO
//   o_tx            out  serial line, idle high, registered
//   o_busy          out  high while a frame is on the line
//   o_done          out  one-cycle pulse on the last stop-bit cycle
//
// Configuration macro
//   UART_TX_PARITY_EN  adds the even-parity bit
module uart_tx_fifo_drain #(
  parameter int DATAW   = 8,
  parameter int CLK_DIV = 16
) (
  input  logic             clk,
  input  logic             i_rst,
  input  logic             i_fifo_empty,
  input  logic [DATAW-1:0] i_fifo_rd_data,
  output logic             o_fifo_rd_en,
  output logic             o_tx,
  output logic             o_busy,
  output logic             o_done
);

  localparam int DIVW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BITW = (DATAW > 1) ? $clog2(DATAW) : 1;
  localparam logic [DIVW-1:0] DIV_LAST = DIVW'(CLK_DIV - 1);
  localparam logic [BITW-1:0] BIT_LAST = BITW'(DATAW - 1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t           state_q, state_d;
  logic [DIVW-1:0]  div_q, div_d;
  logic [BITW-1:0]  bit_q, bit_d;
  logic [DATAW-1:0] shreg_q, shreg_d;
  logic             tx_d, busy_d, done_d;
  logic             bit_end;

  assign bit_end = (div_q == DIV_LAST);

  // Next-state logic. The data register is rotated rather than shifted, so
  // after DATAW bit periods it holds the original byte again; the parity bit
  // can then be taken from it without keeping a separate parity register.
  always_comb begin
    state_d      = state_q;
    div_d        = div_q;
    bit_d        = bit_q;
    shreg_d      = shreg_q;
    o_fifo_rd_en = 1'b0;

    if (state_q != IDLE) begin
      div_d = bit_end ? '0 : div_q + DIVW'(1);
    end

    case (state_q)
      IDLE: begin
        div_d = '0;
        bit_d = '0;
        if (!i_fifo_empty && !i_rst) begin
          o_fifo_rd_en = 1'b1;
          shreg_d      = i_fifo_rd_data;
          state_d      = START;
        end
      end
      START: begin
        if (bit_end) state_d = DATA;
      end
      DATA: begin
        if (bit_end) begin
          shreg_d = {shreg_q[0], shreg_q[DATAW-1:1]};
          if (bit_q == BIT_LAST) begin
            bit_d = '0;
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            bit_d = bit_q + BITW'(1);
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_end) state_d = STOP;
      end
`endif
      STOP: begin
        // Back-to-back frames: pop the next byte on the last stop cycle.
        if (bit_end) begin
          if (!i_fifo_empty && !i_rst) begin
            o_fifo_rd_en = 1'b1;
            shreg_d      = i_fifo_rd_data;
            state_d      = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so the registered copies line
  // up cycle-for-cycle with the state they describe.
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      START:  tx_d = 1'b0;
      DATA:   tx_d = shreg_d[0];
`ifdef UART_TX_PARITY_EN
      PARITY: tx_d = ^shreg_d;
`endif
      default: tx_d = 1'b1;
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_d == STOP) && (div_d == DIV_LAST);
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      o_tx    <= 1'b1;
      o_busy  <= 1'b0;
      o_done  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      o_tx    <= tx_d;
      o_busy  <= busy_d;
      o_done  <= done_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo_drain.sv
// tb_uart_tx_fifo_drain
//   Drives uart_tx_fifo_drain from a queue-based FIFO model (16 entries,
//   empty flag registered one cycle after a write) and compares o_tx,
//   o_busy, o_done and o_fifo_rd_en every cycle against a frame-timing
//   reference computed from pop times and byte values.
module tb_uart_tx_fifo_drain;

  localparam int DATAW   = 8;
  localparam int CLK_DIV = 4;
`ifdef UART_TX_PARITY_EN
  localparam int FRAME = (DATAW + 3) * CLK_DIV;
`else
  localparam int FRAME = (DATAW + 2) * CLK_DIV;
`endif

  typedef struct {
    int         pop;
    logic [7:0] data;
  } frame_t;

  logic       clk = 1'b0;
  logic       i_rst = 1'b1;
  logic       fifo_empty = 1'b1;
  logic [7:0] fifo_rd_data = 8'h00;
  logic       rd_en, tx, busy, done;

  int         vectors = 0;
  int         miscompares = 0;
  int         cyc = 0;
  int         lastPop = -1000;
  int         popCount = 0;
  int         doneCount = 0;
  int         emptyPops = 0;
  frame_t     frames[$];
  logic [7:0] fifoQ[$];
  logic [7:0] poppedQ[$];
  logic [7:0] writtenQ[$];

  uart_tx_fifo_drain #(.DATAW(DATAW), .CLK_DIV(CLK_DIV)) dut (
    .clk           (clk),
    .i_rst         (i_rst),
    .i_fifo_empty  (fifo_empty),
    .i_fifo_rd_data(fifo_rd_data),
    .o_fifo_rd_en  (rd_en),
    .o_tx          (tx),
    .o_busy        (busy),
    .o_done        (done)
  );

  always #5 clk = ~clk;

  // Value of the serial line k bit periods into a frame carrying b.
  function automatic logic bitOf(input logic [7:0] b, input int k);
    logic [7:0] t;
    if (k == 0) return 1'b0;
    if (k <= DATAW) begin
      t = b >> (k - 1);
      return t[0];
    end
`ifdef UART_TX_PARITY_EN
    if (k == DATAW + 1) return ^b;
`endif
    return 1'b1;
  endfunction

  // Expected outputs at cycle c from the list of scheduled frames.
  function automatic void expAt(input int c, output logic eTx, output logic eBusy,
                                output logic eDone, output logic eRd);
    int k;
    eTx = 1'b1; eBusy = 1'b0; eDone = 1'b0; eRd = 1'b0;
    foreach (frames[i]) begin
      if (c == frames[i].pop) eRd = 1'b1;
      if (c > frames[i].pop && c <= frames[i].pop + FRAME) begin
        k = (c - frames[i].pop - 1) / CLK_DIV;
        eBusy = 1'b1;
        eTx = bitOf(frames[i].data, k);
        eDone = (c == frames[i].pop + FRAME);
      end
    end
  endfunction

  task automatic checkBit(input string tag, input logic obs, input logic expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, expv);
    end
  endtask

  task automatic checkInt(input string tag, input int obs, input int expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic checkOutput();
    logic eTx, eBusy, eDone, eRd;
    expAt(cyc, eTx, eBusy, eDone, eRd);
    if (done === 1'b1) doneCount++;
    checkBit("tx", tx, eTx);
    checkBit("busy", busy, eBusy);
    checkBit("done", done, eDone);
    checkBit("rd_en", rd_en, eRd);
  endtask

  // One clock cycle: update the reference and FIFO model, drive inputs,
  // advance past the edge and check at the following negedge.
  task automatic applyStimulus(input logic rst, input logic wr, input logic [7:0] data);
    frame_t f;
    int a;
    if (rst) begin
      frames.delete();
      lastPop = -1000;
    end else if (wr) begin
      a = cyc + 1;
      f.pop = (a > lastPop + FRAME) ? a : lastPop + FRAME;
      f.data = data;
      frames.push_back(f);
      lastPop = f.pop;
      writtenQ.push_back(data);
    end
    if (rd_en === 1'b1) begin
      if (fifo_empty || fifoQ.size() == 0) emptyPops++;
      else begin
        poppedQ.push_back(fifoQ.pop_front());
        popCount++;
      end
    end
    if (wr) fifoQ.push_back(data);
    i_rst = rst;
    @(posedge clk);
    cyc++;
    fifo_empty   <= (fifoQ.size() == 0);
    fifo_rd_data <= (fifoQ.size() != 0) ? fifoQ[0] : 8'h00;
    @(negedge clk);
    checkOutput();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 8'h00);
  endtask

  task automatic checkDrained(input string tag);
    checkInt({tag, "_count"}, poppedQ.size(), writtenQ.size());
    for (int i = 0; i < poppedQ.size() && i < writtenQ.size(); i++)
      checkInt({tag, "_byte"}, int'(poppedQ[i]), int'(writtenQ[i]));
    poppedQ.delete();
    writtenQ.delete();
  endtask

  initial begin
    int p0, d0, gap;
    logic [7:0] rb;

    $display("[TB] reset");
    repeat (3) applyStimulus(1'b1, 1'b0, 8'h00);
    idle(6);
    checkInt("t1_pops", popCount, 0);
    checkBit("t1_empty", fifo_empty, 1'b1);

    $display("[TB] single byte 0xA5");
    p0 = popCount; d0 = doneCount;
    applyStimulus(1'b0, 1'b1, 8'hA5);
    idle(FRAME + 6);
    checkInt("t2_pops", popCount - p0, 1);
    checkInt("t2_done", doneCount - d0, 1);
    checkDrained("t2");

    $display("[TB] back-to-back 00 FF 3C");
    p0 = popCount; d0 = doneCount;
    applyStimulus(1'b0, 1'b1, 8'h00);
    applyStimulus(1'b0, 1'b1, 8'hFF);
    applyStimulus(1'b0, 1'b1, 8'h3C);
    idle(3 * FRAME + 6);
    checkInt("t3_pops", popCount - p0, 3);
    checkInt("t3_done", doneCount - d0, 3);
    checkInt("t3_fifo_left", fifoQ.size(), 0);
    checkDrained("t3");

    $display("[TB] sixteen bytes");
    for (int i = 0; i < 16; i++) applyStimulus(1'b0, 1'b1, 8'(i));
    idle(16 * FRAME + 6);
    checkDrained("t4");

    $display("[TB] random bytes and gaps");
    for (int i = 0; i < 12; i++) begin
      rb = 8'($urandom);
      applyStimulus(1'b0, 1'b1, rb);
      gap = int'($urandom_range(0, FRAME + 8));
      idle(gap);
    end
    idle(12 * FRAME + 6);
    checkDrained("rand");

    $display("[TB] reset mid-frame");
    p0 = popCount;
    applyStimulus(1'b0, 1'b1, 8'h81);
    idle(13);
    checkBit("t5_before_rst", tx, 1'b0);
    applyStimulus(1'b1, 1'b0, 8'h00);
    checkBit("t5_abort_tx", tx, 1'b1);
    checkBit("t5_abort_busy", busy, 1'b0);
    idle(FRAME + 10);
    checkInt("t5_pops", popCount - p0, 1);
    checkBit("t5_idle_tx", tx, 1'b1);
    poppedQ.delete();
    writtenQ.delete();

`ifdef UART_TX_PARITY_EN
    $display("[TB] parity frames");
    applyStimulus(1'b0, 1'b1, 8'h07);
    idle(38);
    checkBit("t6_parity07", tx, 1'b1);
    idle(FRAME);
    applyStimulus(1'b0, 1'b1, 8'h03);
    idle(38);
    checkBit("t6_parity03", tx, 1'b0);
    idle(FRAME);
    checkDrained("t6");
`endif

    checkInt("empty_pops", emptyPops, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
